pulse_detect: RTL and testbench

PULSE_DETECT -- requirements
Module: pulse_detect

---
 rtl/pulse_detect.sv | 152 +++++++++++++++
 tb/tb_pulse_detect.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_detect.sv
// Magnitude-threshold pulse detector on strobed I/Q samples with width qualification and holdoff.
// Define PULSE_DETECT_PEAK_EN to build peak tracking; otherwise pulse_peak is tied to 0.
//
// state     | meaning
// S_IDLE    | waiting for a sample at or above threshold
// S_ABOVE   | inside a pulse, accumulating width (and peak)
// S_HOLDOFF | ignoring HOLDOFF samples after a qualified detection
module pulse_detect #(
  parameter int BIT_WIDTH = 16,
  parameter int CNT_WIDTH = 16,
  parameter int HOLDOFF   = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        strobe_in,
  input  logic signed [BIT_WIDTH-1:0] i_in,
  input  logic signed [BIT_WIDTH-1:0] q_in,
  input  logic        [BIT_WIDTH:0]   threshold,
  input  logic        [CNT_WIDTH-1:0] min_width,
  output logic                        detect,
  output logic        [CNT_WIDTH-1:0] pulse_width,
  output logic        [BIT_WIDTH:0]   pulse_peak,
  output logic        [CNT_WIDTH-1:0] timestamp,
  output logic                        busy
);

  localparam int HW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [BIT_WIDTH:0]   MAG_ONE   = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = 1;
  localparam logic [HW-1:0]        HOLD_ONE  = 1;
  localparam logic [HW-1:0]        HOLD_LOAD = HW'(HOLDOFF);

  typedef enum logic [1:0] {S_IDLE, S_ABOVE, S_HOLDOFF} state_t;

  state_t               state;
  logic [BIT_WIDTH:0]   i_ext, q_ext, i_abs, q_abs;
  logic [BIT_WIDTH:0]   mag;
  logic                 mag_valid;
  logic [CNT_WIDTH-1:0] mag_ts;
  logic [CNT_WIDTH-1:0] sample_cnt;
  logic [CNT_WIDTH-1:0] width;
  logic [CNT_WIDTH-1:0] start_ts;
  logic [CNT_WIDTH-1:0] min_eff;
  logic [HW-1:0]        hold_cnt;
  logic                 above;

  // One extra bit so that the most negative input has a representable magnitude.
  assign i_ext   = {i_in[BIT_WIDTH-1], i_in};
  assign q_ext   = {q_in[BIT_WIDTH-1], q_in};
  assign i_abs   = i_in[BIT_WIDTH-1] ? (~i_ext + MAG_ONE) : i_ext;
  assign q_abs   = q_in[BIT_WIDTH-1] ? (~q_ext + MAG_ONE) : q_ext;
  assign above   = (mag >= threshold);
  assign min_eff = (min_width == '0) ? CNT_ONE : min_width;

  always_ff @(posedge clock) begin
    if (reset) begin
      mag        <= '0;
      mag_valid  <= 1'b0;
      mag_ts     <= '0;
      sample_cnt <= '0;
    end else begin
      mag_valid <= strobe_in;
      if (strobe_in) begin
        mag        <= i_abs + q_abs;
        mag_ts     <= sample_cnt;
        sample_cnt <= sample_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      detect      <= 1'b0;
      width       <= '0;
      start_ts    <= '0;
      hold_cnt    <= '0;
      pulse_width <= '0;
      timestamp   <= '0;
    end else begin
      detect <= 1'b0;
      if (!enable) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else if (mag_valid) begin
        case (state)
          S_IDLE: begin
            if (above) begin
              state    <= S_ABOVE;
              busy     <= 1'b1;
              width    <= CNT_ONE;
              start_ts <= mag_ts;
            end
          end
          S_ABOVE: begin
            if (above) begin
              if (width != '1) width <= width + CNT_ONE;
            end else if (width >= min_eff) begin
              state       <= S_HOLDOFF;
              hold_cnt    <= HOLD_LOAD;
              detect      <= 1'b1;
              pulse_width <= width;
              timestamp   <= start_ts;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          S_HOLDOFF: begin
            // A load of 0 behaves like 1: leave on the first holdoff sample.
            if (hold_cnt <= HOLD_ONE) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - HOLD_ONE;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PULSE_DETECT_PEAK_EN
  logic [BIT_WIDTH:0] peak;

  always_ff @(posedge clock) begin
    if (reset) begin
      peak       <= '0;
      pulse_peak <= '0;
    end else if (enable && mag_valid) begin
      if (state == S_IDLE && above) begin
        peak <= mag;
      end else if (state == S_ABOVE) begin
        if (above) begin
          if (mag > peak) peak <= mag;
        end else if (width >= min_eff) begin
          pulse_peak <= peak;
        end
      end
    end
  end
`else
  assign pulse_peak = '0;
`endif

endmodule

// File: tb/tb_pulse_detect.sv
// Self-checking bench for pulse_detect: directed scenarios plus randomized sample streams
// checked against a run-length reference model over the recorded magnitudes.
module tb_pulse_detect;

  localparam int BW = 16;
  localparam int CW = 16;
  localparam int HO = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 strobe_in;
  logic signed [BW-1:0] i_in, q_in;
  logic [BW:0]          threshold;
  logic [CW-1:0]        min_width;
  logic                 detect, busy;
  logic [CW-1:0]        pulse_width, timestamp;
  logic [BW:0]          pulse_peak;

  typedef struct {int w; int p; int t;} det_t;

  int   checks = 0;
  int   failures = 0;
  int   det_count = 0;
  logic prev_det = 1'b0;
  det_t seen[$];
  det_t expq[$];
  int   mags[$];

  pulse_detect #(.BIT_WIDTH(BW), .CNT_WIDTH(CW), .HOLDOFF(HO)) dut (
    .clock(clock), .reset(reset), .enable(enable), .strobe_in(strobe_in),
    .i_in(i_in), .q_in(q_in), .threshold(threshold), .min_width(min_width),
    .detect(detect), .pulse_width(pulse_width), .pulse_peak(pulse_peak),
    .timestamp(timestamp), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && detect) begin
      check("detect_single_cycle", prev_det, 0);
      det_count++;
      seen.push_back('{int'(pulse_width), int'(pulse_peak), int'(timestamp)});
    end
    prev_det = detect;
  end

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int exp_peak(input int p);
`ifdef PULSE_DETECT_PEAK_EN
    return p;
`else
    return 0 * p;
`endif
  endfunction

  task automatic send(input int i, input int q);
    i_in = BW'(i);
    q_in = BW'(q);
    strobe_in = 1'b1;
    mags.push_back(iabs(i) + iabs(q));
    @(posedge clock);
    #1;
    strobe_in = 1'b0;
  endtask

  task automatic zeros(input int n);
    repeat (n) send(0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    strobe_in = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    mags.delete();
    seen.delete();
    det_count = 0;
  endtask

  // Reference: scan the magnitude list run by run, applying threshold, min width and holdoff.
  task automatic build_expected(input int thr, input int mw);
    int j, len, pk, n, need;
    expq.delete();
    n = mags.size();
    need = (mw == 0) ? 1 : mw;
    j = 0;
    while (j < n) begin
      if (mags[j] >= thr) begin
        len = 0;
        pk = 0;
        while (j + len < n && mags[j + len] >= thr) begin
          if (mags[j + len] > pk) pk = mags[j + len];
          len++;
        end
        if (j + len >= n) break;
        if (len >= need) begin
          expq.push_back('{len, exp_peak(pk), j % 65536});
          j = j + len + 1 + HO;
        end else begin
          j = j + len + 1;
        end
      end else begin
        j++;
      end
    end
  endtask

  initial begin
    int a, b, hi, thr_i, sel;
    reset = 1'b1; enable = 1'b1; strobe_in = 1'b0; i_in = '0; q_in = '0;
    threshold = 17'd1000; min_width = 16'd3;

    do_reset();
    idle(5);
    check("rst_detect", detect, 0);
    check("rst_busy", busy, 0);
    check("rst_width", pulse_width, 0);
    check("rst_peak", pulse_peak, 0);
    check("rst_ts", timestamp, 0);

    zeros(10);
    repeat (5) send(2000, -500);
    check("basic_busy", busy, 1);
    zeros(8);
    check("basic_count", det_count, 1);
    check("basic_width", pulse_width, 5);
    check("basic_peak", pulse_peak, exp_peak(2500));
    check("basic_ts", timestamp, 10);
    check("basic_idle", busy, 0);

    repeat (2) send(1500, 0);
    zeros(6);
    check("short_count", det_count, 1);
    check("short_busy", busy, 0);
    check("short_width", pulse_width, 5);
    check("short_ts", timestamp, 10);

    do_reset();
    repeat (3) send(-32768, -32768);
    zeros(8);
    check("fs_count", det_count, 1);
    check("fs_width", pulse_width, 3);
    check("fs_peak", pulse_peak, exp_peak(65536));
    check("fs_ts", timestamp, 0);

    do_reset();
    repeat (5) send(2000, -500);
    zeros(2);
    repeat (5) send(2000, -500);
    zeros(8);
    check("hold_ignored_count", det_count, 1);
    check("hold_ignored_ts", timestamp, 0);

    do_reset();
    repeat (5) send(2000, -500);
    zeros(6);
    repeat (5) send(2000, -500);
    zeros(8);
    check("hold_after_count", det_count, 2);
    check("hold_after_ts", timestamp, 11);
    check("hold_after_width", pulse_width, 5);

    do_reset();
    repeat (3) send(2000, -500);
    check("rstmid_busy_pre", busy, 1);
    i_in = 16'sd2000; q_in = -16'sd500; strobe_in = 1'b1; reset = 1'b1;
    @(posedge clock);
    #1;
    strobe_in = 1'b0;
    check("rstmid_busy_post", busy, 0);
    reset = 1'b0;
    send(2000, -500);
    zeros(8);
    check("rstmid_count", det_count, 0);
    check("rstmid_width", pulse_width, 0);

    do_reset();
    repeat (5) send(2000, -500);
    zeros(8);
    repeat (3) send(2000, -500);
    check("enmid_busy_pre", busy, 1);
    enable = 1'b0;
    send(2000, -500);
    check("enmid_busy_post", busy, 0);
    enable = 1'b1;
    send(2000, -500);
    zeros(8);
    check("enmid_count", det_count, 1);
    check("enmid_width_held", pulse_width, 5);
    check("enmid_ts_held", timestamp, 0);
    check("enmid_peak_held", pulse_peak, exp_peak(2500));

    for (int r = 0; r < 3; r++) begin
      thr_i = (r == 2) ? int'($urandom_range(0, 2000)) : 1000;
      threshold = 17'(thr_i);
      min_width = 16'($urandom_range(0, 4));
      do_reset();
      hi = 0;
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        if ($urandom_range(0, 3) == 0) hi = 1 - hi;
        sel = int'($urandom_range(0, 15));
        if (sel == 0) begin
          a = -32768; b = int'($urandom_range(0, 32767));
        end else if (sel == 1) begin
          a = thr_i; b = 0;
        end else if (sel == 2) begin
          a = 0; b = (thr_i > 0) ? -(thr_i - 1) : 0;
        end else if (hi != 0) begin
          a = int'($urandom_range(500, 1400)); b = int'($urandom_range(0, 700));
        end else begin
          a = int'($urandom_range(0, 500)); b = int'($urandom_range(0, 400));
        end
        if ($urandom_range(0, 1) == 1 && a != -32768) a = -a;
        if ($urandom_range(0, 1) == 1) b = -b;
        send(a, b);
      end
      zeros(12);
      build_expected(thr_i, int'(min_width));
      check("rnd_count", seen.size(), expq.size());
      for (int k = 0; k < seen.size() && k < expq.size(); k++) begin
        check("rnd_width", seen[k].w, expq[k].w);
        check("rnd_peak", seen[k].p, expq[k].p);
        check("rnd_ts", seen[k].t, expq[k].t);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
